// File: rtl/alu_writeback_sequencer_pkg.sv
// rtl/alu_writeback_sequencer_pkg.sv - shared widths, ALU opcodes and sequencer state codes
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_READ  = 3'd1;
    localparam seq_state_t ST_EXEC  = 3'd2;
    localparam seq_state_t ST_MUL   = 3'd3;
    localparam seq_state_t ST_WRITE = 3'd4;

endpackage

// File: rtl/alu_writeback_sequencer_if.sv
// rtl/alu_writeback_sequencer_if.sv - decoded-instruction handshake into the execute stage
interface alu_writeback_sequencer_if import cpu_pkg::*; #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic              InValid;
    logic              InReady;
    alu_op_t           InOp;
    logic [ADDR_W-1:0] InDst;
    logic [ADDR_W-1:0] InSrc;
    logic              InUseImm;
    logic [DATA_W-1:0] InImm;

    modport master (
        output InValid, InOp, InDst, InSrc, InUseImm, InImm,
        input  InReady
    );

    modport slave (
        input  InValid, InOp, InDst, InSrc, InUseImm, InImm,
        output InReady
    );
endinterface

// File: rtl/alu_writeback_sequencer_serial_multiplier.sv
// rtl/alu_writeback_sequencer_serial_multiplier.sv - unsigned shift-add multiplier, one partial product per cycle
module serial_multiplier #(
    parameter int DATA_W    = 16,
    parameter int MUL_STEPS = DATA_W
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DATA_W-1:0]     OpA,
    input  logic [DATA_W-1:0]     OpB,
    output logic                  Done,
    output logic [2*DATA_W-1:0]   Product
);
    localparam int CNT_W = $clog2(MUL_STEPS + 1);

    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    count;
    logic                busy;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            busy    <= 1'b0;
            Done    <= 1'b0;
        end else if (Start) begin
            Product <= '0;
            mcand   <= {{DATA_W{1'b0}}, OpA};
            mplier  <= OpB;
            count   <= '0;
            busy    <= 1'b1;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (busy) begin
                if (mplier[0]) begin
                    Product <= Product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                // Done lands one cycle after the last accumulate so Product is already final.
                if (count == CNT_W'(MUL_STEPS - 1)) begin
                    busy <= 1'b0;
                    Done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/alu_writeback_sequencer.sv
// rtl/alu_writeback_sequencer.sv - execute stage owning read/compute/write-back timing of the 64x16 reg file
module alu_writeback_sequencer #(
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int MUL_STEPS = DATA_W
) (
    input  logic                 Clock,
    input  logic                 Reset,
    alu_writeback_sequencer_if.slave in_if,
    output logic [ADDR_W-1:0]    AddressA,
    output logic [ADDR_W-1:0]    AddressB,
    input  logic [DATA_W-1:0]    ReadDataA,
    input  logic [DATA_W-1:0]    ReadDataB,
    output logic [DATA_W-1:0]    WriteData,
    output logic                 WriteEnable,
    output logic                 FlagZ,
    output logic                 FlagC,
    output logic                 FlagN,
    output logic                 Done
);
    import cpu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);

    seq_state_t          state;
    alu_op_t             op;
    logic                use_imm;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic                res_c;
    logic [DATA_W-1:0]   opb_sel;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic [DATA_W:0]     wide;
    logic [SH_W-1:0]     amt;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] product;

    assign in_if.InReady = (state == ST_IDLE);
    assign WriteEnable   = (state == ST_WRITE);
    assign Done          = (state == ST_WRITE);
    assign opb_sel       = use_imm ? imm : ReadDataB;
    assign amt           = opb[SH_W-1:0];
    // The multiplier loads straight from the read ports so its final step lines up with cycle 2+MUL_STEPS.
    assign mul_start     = (state == ST_READ) && (op == OP_MUL);

    serial_multiplier #(
        .DATA_W   (DATA_W),
        .MUL_STEPS(MUL_STEPS)
    ) u_mul (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (mul_start),
        .OpA    (ReadDataA),
        .OpB    (opb_sel),
        .Done   (mul_done),
        .Product(product)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (op)
            OP_SUB: begin
                alu_res = opa - opb;
                alu_c   = (opa < opb);
            end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_SHL: begin
                wide    = {1'b0, opa} << amt;
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_SHR: begin
                wide    = {opa, 1'b0} >> amt;
                alu_res = wide[DATA_W:1];
                alu_c   = wide[0];
            end
            default: begin
                wide    = {1'b0, opa} + {1'b0, opb};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            op        <= OP_ADD;
            use_imm   <= 1'b0;
            imm       <= '0;
            AddressA  <= '0;
            AddressB  <= '0;
            opa       <= '0;
            opb       <= '0;
            WriteData <= '0;
            res_c     <= 1'b0;
            FlagZ     <= 1'b0;
            FlagC     <= 1'b0;
            FlagN     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_if.InValid) begin
                        op       <= in_if.InOp;
                        use_imm  <= in_if.InUseImm;
                        imm      <= in_if.InImm;
                        AddressA <= in_if.InDst;
                        AddressB <= in_if.InSrc;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    opa   <= ReadDataA;
                    opb   <= opb_sel;
                    state <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
                ST_EXEC: begin
                    WriteData <= alu_res;
                    res_c     <= alu_c;
                    state     <= ST_WRITE;
                end
                ST_MUL: begin
                    if (mul_done) begin
                        WriteData <= product[DATA_W-1:0];
                        res_c     <= |product[2*DATA_W-1:DATA_W];
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    FlagZ <= (WriteData == '0);
                    FlagN <= WriteData[DATA_W-1];
                    FlagC <= res_c;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// tb/tb_alu_writeback_sequencer.sv - directed bench with reg file model and write-back scoreboard
module tb_alu_writeback_sequencer;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  AddressA, AddressB;
    logic [15:0] ReadDataA, ReadDataB, WriteData;
    logic        WriteEnable, FlagZ, FlagC, FlagN, Done;

    always #5 Clock = ~Clock;

    alu_writeback_sequencer_if in_if ();

    alu_writeback_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .in_if      (in_if),
        .AddressA   (AddressA),
        .AddressB   (AddressB),
        .ReadDataA  (ReadDataA),
        .ReadDataB  (ReadDataB),
        .WriteData  (WriteData),
        .WriteEnable(WriteEnable),
        .FlagZ      (FlagZ),
        .FlagC      (FlagC),
        .FlagN      (FlagN),
        .Done       (Done)
    );

    logic [15:0] rf [64] = '{default: 16'h0000};
    logic        pre_we   = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    assign ReadDataA = rf[AddressA];
    assign ReadDataB = rf[AddressB];

    always @(posedge Clock) begin
        if (WriteEnable) rf[AddressA] <= WriteData;
        if (pre_we) rf[pre_addr] <= pre_data;
    end

    typedef struct {
        logic [5:0]  dst;
        logic [15:0] data;
        logic        c;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   we_count = 0;
    int   accepts = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ref_alu(input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
        int          amt;
        logic [31:0] p;
        amt = int'(b[3:0]);
        case (op)
            OP_SUB: return {a < b, a - b};
            OP_AND: return {1'b0, a & b};
            OP_OR:  return {1'b0, a | b};
            OP_XOR: return {1'b0, a ^ b};
            OP_SHL: if (amt == 0) return {1'b0, a}; else return {a[16-amt], a << amt};
            OP_SHR: if (amt == 0) return {1'b0, a}; else return {a[amt-1], a >> amt};
            OP_MUL: begin
                p = a * b;
                return {|p[31:16], p[15:0]};
            end
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    logic        pend = 1'b0;
    logic [15:0] pd;
    logic        pc;
    exp_t        mon_e;

    always @(negedge Clock) begin
        if (pend) begin
            check("flag_z", FlagZ, pd == 16'h0000);
            check("flag_n", FlagN, pd[15]);
            check("flag_c", FlagC, pc);
            pend = 1'b0;
        end
        if (WriteEnable || Done) begin
            we_count++;
            check("done_with_we", Done, WriteEnable);
            if (sb.size() == 0) begin
                check("unexpected_we", WriteEnable, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", AddressA, mon_e.dst);
                check("wr_data", WriteData, mon_e.data);
                check("latency", cyc - mon_e.acc + 1, mon_e.lat);
                pd   = mon_e.data;
                pc   = mon_e.c;
                pend = 1'b1;
            end
        end
    end

    task automatic set_reg(input logic [5:0] a, input logic [15:0] v);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(negedge Clock);
        pre_we   = 1'b0;
    endtask

    task automatic issue(input alu_op_t op, input logic [5:0] d, input logic [5:0] s, input logic ui,
                         input logic [15:0] imm, input logic hold, output int waited);
        exp_t        e;
        logic [16:0] r;
        in_if.InOp     = op;
        in_if.InDst    = d;
        in_if.InSrc    = s;
        in_if.InUseImm = ui;
        in_if.InImm    = imm;
        in_if.InValid  = 1'b1;
        waited = 0;
        while (in_if.InReady !== 1'b1 && waited < 200) begin
            @(negedge Clock);
            waited++;
        end
        if (waited >= 200) check("accept_timeout", in_if.InReady, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        accepts++;
        check("busy_after_accept", in_if.InReady, 1'b0);
        r = ref_alu(op, rf[d], ui ? imm : rf[s]);
        e.dst  = d;
        e.data = r[15:0];
        e.c    = r[16];
        e.acc  = cyc;
        e.lat  = (op == OP_MUL) ? 19 : 3;
        sb.push_back(e);
        if (!hold) in_if.InValid = 1'b0;
    endtask

    task automatic finish_instr();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge Clock);
            t++;
        end
        if (sb.size() != 0) check("we_timeout", sb.size(), 0);
        @(negedge Clock);
    endtask

    task automatic run(input string tag, input alu_op_t op, input logic [5:0] d, input logic [5:0] s,
                       input logic ui, input logic [15:0] imm, input logic [15:0] exp_data,
                       input logic z, input logic c, input logic n);
        int w;
        issue(op, d, s, ui, imm, 1'b0, w);
        finish_instr();
        check({tag, "_data"}, rf[d], exp_data);
        check({tag, "_z"}, FlagZ, z);
        check({tag, "_c"}, FlagC, c);
        check({tag, "_n"}, FlagN, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stalled");
    end

    initial begin
        int w;
        int wc;
        in_if.InValid  = 1'b0;
        in_if.InOp     = OP_ADD;
        in_if.InDst    = '0;
        in_if.InSrc    = '0;
        in_if.InUseImm = 1'b0;
        in_if.InImm    = '0;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst_addr_a", AddressA, 6'd0);
        check("rst_addr_b", AddressB, 6'd0);
        check("rst_wdata", WriteData, 16'h0000);
        check("rst_we", WriteEnable, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_flags", {FlagZ, FlagC, FlagN}, 3'b000);
        check("rst_ready", in_if.InReady, 1'b1);
        Reset = 1'b0;
        @(negedge Clock);

        set_reg(6'd1, 16'h7FFF);
        set_reg(6'd2, 16'h0001);
        run("add_ovf", OP_ADD, 6'd1, 6'd2, 1'b0, 16'h0, 16'h8000, 1'b0, 1'b0, 1'b1);

        set_reg(6'd3, 16'h0005);
        run("sub_borrow", OP_SUB, 6'd3, 6'd0, 1'b1, 16'h0006, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        set_reg(6'd7, 16'h1234);
        set_reg(6'd8, 16'h1234);
        run("sub_equal", OP_SUB, 6'd7, 6'd8, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0, 1'b0);

        set_reg(6'd4, 16'h0100);
        set_reg(6'd5, 16'h0100);
        run("mul_hi", OP_MUL, 6'd4, 6'd5, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
        set_reg(6'd4, 16'h0003);
        set_reg(6'd5, 16'h0007);
        run("mul_lo", OP_MUL, 6'd4, 6'd5, 1'b0, 16'h0, 16'h0015, 1'b0, 1'b0, 1'b0);

        set_reg(6'd6, 16'h8001);
        run("shl1", OP_SHL, 6'd6, 6'd0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0);
        set_reg(6'd9, 16'h0003);
        run("shr1", OP_SHR, 6'd9, 6'd0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
        set_reg(6'd10, 16'hA5A5);
        run("shl0", OP_SHL, 6'd10, 6'd0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b0, 1'b1);

        set_reg(6'd11, 16'h00F0);
        run("xor_self", OP_XOR, 6'd11, 6'd11, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0, 1'b0);

        set_reg(6'd20, 16'($urandom));
        set_reg(6'd21, 16'($urandom));
        set_reg(6'd22, 16'($urandom));
        set_reg(6'd23, 16'($urandom));
        set_reg(6'd24, 16'h0001);
        set_reg(6'd25, 16'h0002);
        issue(OP_AND, 6'd20, 6'd21, 1'b0, 16'h0, 1'b1, w);
        issue(OP_OR, 6'd22, 6'd23, 1'b0, 16'h0, 1'b1, w);
        check("b2b_wait_and", w, 3);
        issue(OP_MUL, 6'd20, 6'd22, 1'b0, 16'h0, 1'b1, w);
        check("b2b_wait_or", w, 3);
        issue(OP_XOR, 6'd21, 6'd20, 1'b0, 16'h0, 1'b1, w);
        check("b2b_wait_mul", w, 19);
        issue(OP_SUB, 6'd24, 6'd25, 1'b0, 16'h0, 1'b0, w);
        check("b2b_wait_xor", w, 3);
        finish_instr();
        check("b2b_sub_data", rf[24], 16'hFFFF);
        check("b2b_sub_cn", {FlagC, FlagN}, 2'b11);
        check("we_per_accept", we_count, accepts);

        set_reg(6'd12, 16'h0009);
        set_reg(6'd13, 16'h0003);
        wc = we_count;
        issue(OP_MUL, 6'd12, 6'd13, 1'b0, 16'h0, 1'b0, w);
        repeat (9) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        sb.delete();
        check("midrst_ready", in_if.InReady, 1'b1);
        check("midrst_we", WriteEnable, 1'b0);
        check("midrst_flags", {FlagZ, FlagC, FlagN}, 3'b000);
        repeat (30) @(negedge Clock);
        check("midrst_no_we", we_count, wc);
        check("midrst_dst_kept", rf[12], 16'h0009);

        run("post_rst_add", OP_ADD, 6'd12, 6'd13, 1'b0, 16'h0, 16'h000C, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
